// File: rtl/addsub_serial4.sv
// Bit-serial-by-nibble adder/subtractor: one 4-bit carry-lookahead slice per clock,
// LSB slice first, with carry, signed overflow and a one-cycle done pulse.
module addsub_serial4 #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sub,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic [4*NIBBLES-1:0]   s,
    output logic                   cout,
    output logic                   ovf,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned W       = 4 * NIBBLES;
    localparam int unsigned IdxW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;      // already inverted for subtract
    logic [W-1:0]      s_q;
    logic              carry_q;
    logic [IdxW-1:0]   idx_q;
    logic              cout_q;
    logic              ovf_q;

    logic              accept;
    logic              last_slice;
    logic [IdxW+1:0]   base;
    logic [3:0]        slice_a;
    logic [3:0]        slice_b;
    logic [3:0]        g;
    logic [3:0]        p;
    logic [4:0]        c;
    logic [3:0]        sum;

    assign last_slice = (idx_q == LastIdx);
    assign base       = {idx_q, 2'b00};

    // Next-state logic; start is only honoured outside RUN.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    accept  = 1'b1;
                end
            end
            StRun: begin
                if (last_slice) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (start) begin
                    state_d = StRun;
                    accept  = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Lookahead carries are flattened sums of products, not a ripple chain.
    always_comb begin
        slice_a = a_q[base +: 4];
        slice_b = b_q[base +: 4];
        g       = slice_a & slice_b;
        p       = slice_a ^ slice_b;
        c[0]    = carry_q;
        c[1]    = g[0] | (p[0] & c[0]);
        c[2]    = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
        c[4]    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);
        sum     = p ^ c[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub | cin;
            idx_q   <= '0;
        end else if (state_q == StRun) begin
            s_q[base +: 4] <= sum;
            carry_q        <= c[4];
            if (last_slice) begin
                idx_q  <= '0;
                cout_q <= c[4];
                ovf_q  <= c[4] ^ c[3];
            end else begin
                idx_q  <= idx_q + IdxW'(1);
            end
        end
    end

    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == StRun);
    assign done = (state_q == StDone);

endmodule

// File: tb/tb_addsub_serial4.sv
// Scoreboard bench for addsub_serial4: stimulus pushes expected results and due cycles,
// a negedge monitor pops and compares whenever done is seen.
module tb_addsub_serial4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub   = 1'b0;
    logic        cin   = 1'b0;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
    logic        busy;
    logic        done;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        v;
        int          due;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    addsub_serial4 #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every done-high negedge must match the oldest pending operation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=1 expected 0 (no op pending, cycle %0d)",
                         cyc);
            end else begin
                e = q.pop_front();
                check("result{s,cout,ovf}", {14'd0, s, cout, ovf}, {14'd0, e.s, e.c, e.v});
                check("done_cycle", cyc, e.due);
            end
        end
    end

    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic msub, input logic mcin);
        logic [15:0] bb;
        logic [16:0] full;
        logic        v;
        bb   = msub ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + {16'd0, (msub ? 1'b1 : mcin)};
        v    = (ma[15] == bb[15]) && (full[15] != ma[15]);
        return {full[15:0], full[16], v};
    endfunction

    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                         input logic icin, input logic [15:0] es, input logic ec,
                         input logic ev);
        @(posedge clk); #1;
        a = ia; b = ib; sub = isub; cin = icin; start = 1'b1;
        q.push_back('{es, ec, ev, cyc + 5});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits (bounded) for the scoreboard to empty, counting busy cycles seen on the way.
    task automatic drain(output int bcnt);
        bcnt = 0;
        for (int i = 0; i < 40 && q.size() != 0; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                          input logic icin, input logic [15:0] es, input logic ec,
                          input logic ev);
        int bc;
        issue(ia, ib, isub, icin, es, ec, ev);
        drain(bc);
        repeat (3) @(negedge clk);
        check("hold{s,cout,ovf}", {14'd0, s, cout, ovf}, {14'd0, es, ec, ev});
    endtask

    initial begin : stim
        int          bc;
        int          bc2;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        logic        rc;
        logic [17:0] m;

        #1;
        check("reset_outputs", {13'd0, s, cout, ovf, busy, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, expected values worked by hand.
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        run_op(16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        run_op(16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        run_op(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        run_op(16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);

        // A start pulsed mid-RUN must be ignored; busy must last four cycles.
        bc = 0;
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
        q.push_back('{16'h2345, 1'b0, 1'b0, cyc + 5});
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        if (busy) bc++;
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        if (busy) bc++;
        @(posedge clk); #1;
        start = 1'b0;
        drain(bc2);
        bc = bc + bc2;
        check("busy_cycles", bc, 4);
        repeat (6) @(negedge clk);
        check("ignored_start_s", {16'd0, s}, {16'd0, 16'h2345});

        // Reset in the second RUN cycle abandons the op at once.
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {13'd0, s, cout, ovf, busy, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post_reset_idle", {30'd0, busy, done}, 32'd0);
        run_op(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

        // Back-to-back issue with start held high across DONE.
        @(posedge clk); #1;
        ra = 16'(($urandom));
        rb = 16'(($urandom));
        rs = 1'($urandom_range(1, 0));
        rc = 1'($urandom_range(1, 0));
        a = ra; b = rb; sub = rs; cin = rc; start = 1'b1;
        m = model(ra, rb, rs, rc);
        q.push_back('{m[17:2], m[1], m[0], cyc + 5});
        for (int i = 1; i < 80; i++) begin
            @(posedge clk); #1;
            ra = 16'(($urandom));
            rb = 16'(($urandom));
            rs = 1'($urandom_range(1, 0));
            rc = 1'($urandom_range(1, 0));
            a = ra; b = rb; sub = rs; cin = rc;
            m = model(ra, rb, rs, rc);
            q.push_back('{m[17:2], m[1], m[0], q[q.size() - 1].due + 5});
            repeat (4) @(posedge clk);
        end
        @(posedge clk); #1;
        start = 1'b0;
        drain(bc);
        repeat (3) @(negedge clk);
        check("final_idle", {30'd0, busy, done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addsub_serial4.md
ADDSUB_SERIAL4 -- requirements
Module: addsub_serial4

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, meaning the operand width in 4-bit slices (operand width W = 4*NIBBLES).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 SHALL have port sub, input, 1 bit: operation select, 0 = a+b, 1 = a-b; sampled with start.
REQ-006 SHALL have ports a and b, input, W bits each: operands, sampled with start.
REQ-007 SHALL have port cin, input, 1 bit: carry-in for add; ignored when sub=1.
REQ-008 SHALL have port s, output, W bits: registered result.
REQ-009 SHALL have port cout, output, 1 bit: carry out of the MSB; for subtract, 1 = no borrow.
REQ-010 SHALL have port ovf, output, 1 bit: two's-complement signed overflow.
REQ-011 SHALL have port busy, output, 1 bit: high while in RUN.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse marking s/cout/ovf valid.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL accept start only in IDLE or DONE; on an accepting edge it SHALL latch a, b' (b' = b when sub=0, ~b when sub=1) and carry c0 (cin when sub=0, 1 when sub=1), clear the slice index to 0, and enter RUN.
REQ-015 SHALL, in RUN, compute one 4-bit slice per clock, LSB slice first, using carry-lookahead: g=a&b', p=a^b', and each internal carry formed from g/p/c0 in parallel, not rippled.
REQ-016 SHALL write the slice sum to s[4i+3:4i] and register that slice's carry-out as the carry-in of slice i+1.
REQ-017 SHALL, after slice NIBBLES-1, register cout = carry out of the MSB and ovf = carry into MSB XOR carry out of MSB, then enter DONE.
REQ-018 SHALL have a latency of exactly NIBBLES+1 rising edges from the accepting edge to the edge at which done rises (5 for the default).
REQ-019 SHALL hold done high for exactly one cycle (the DONE state) and then return to IDLE, unless start is accepted in DONE, in which case it SHALL re-enter RUN directly (back-to-back issue).
REQ-020 SHALL ignore start, a, b, sub and cin while in RUN; the operation in progress SHALL complete unchanged.
REQ-021 SHALL hold s, cout and ovf stable from done until the next accepting edge; s is undefined-by-contract (partially updated) during RUN.
REQ-022 SHALL keep busy=1 exactly in RUN and busy=0 in IDLE and DONE.
REQ-023 SHALL discard any carry beyond cout; results wrap modulo 2^W.

Reset
REQ-024 SHALL, on rst_n low, asynchronously force state IDLE, s=0, cout=0, ovf=0, busy=0, done=0, slice index 0 and internal carry 0.
REQ-025 SHALL, on reset asserted mid-RUN, abandon the operation with no done pulse; the first start after rst_n deasserts SHALL begin a fresh operation.

Verification
REQ-026 Add 0xFFFF+0x0001, cin=0 -> after 5 edges done=1, s=0x0000, cout=1, ovf=0.
REQ-027 Add 0x7FFF+0x0000, cin=1 -> s=0x8000, cout=0, ovf=1; sub 0x8000-0x0001 -> s=0x7FFF, cout=1, ovf=1.
REQ-028 Sub 0x0000-0x0001 -> s=0xFFFF, cout=0 (borrow), ovf=0; cin=1 applied with sub=1 SHALL NOT change the result.
REQ-029 Start with 0x1234+0x1111, then start with 0xFFFF+0xFFFF pulsed two cycles later (during RUN) -> a single done, s=0x2345, busy high for exactly 4 cycles.
REQ-030 rst_n pulsed low during the 2nd RUN cycle -> all outputs 0 immediately, no done; a subsequent 0x0003+0x0004 -> s=0x0007.
REQ-031 start held high across DONE with 80 random operand/sub/cin sets -> back-to-back results with done every 5 cycles, each matching {cout,s}=a+b+cin (add) or a+~b+1 (sub), with ovf checked.
